packet_resolver: RTL and testbench
==================================

// Module: packet_resolver
// PURPOSE
//  Store-and-forward stage directly downstream of the packet classifier. Buffers each Avalon-ST
//  packet, takes the classifier verdict from channel, then forwards matched packets and drops
//  the rest. Feeds the output Avalon-ST port and keeps saturating pass/drop packet counters.
// PARAMETERS
//  DATA_WIDTH     32    symbol-packed data width (multiple of 8)
//  CHANNEL_WIDTH  1     width of classifier channel (verdict = |channel)
//  FIFO_DEPTH     256   packet buffer depth in words (power of 2, >= 4)
//  CNT_WIDTH      16    width of pass/drop counters
// PORTS
//  clk_i        in   1          single clock
//  rst_n_i      in   1          asynchronous, active-low reset
//  ast_sink_if  sink avalon_st  data/valid/ready/sop/eop/empty/channel from the classifier
//  ast_src_if   src  avalon_st  forwarded packets; channel driven '0
//  pass_cnt_o   out  CNT_WIDTH  packets forwarded, saturates at all-ones
//  drop_cnt_o   out  CNT_WIDTH  packets dropped, saturates at all-ones
// BEHAVIOUR
//  Reset: all pointers 0, write FSM IDLE, output stage empty; src valid/sop/eop 0, data/empty '0,
//   sink ready 0 during reset, counters 0. Reset mid-packet discards all buffered and partial data.
//  Buffer: each word stores {data, sop, eop, empty}. Pointers are ADDR_W+1 bits
//   (ADDR_W = $clog2(FIFO_DEPTH)) with a wrap bit. wr_ptr = speculative write, cmt_ptr = end of
//   last passed packet, rd_ptr = read side. Full when wr_ptr-rd_ptr == FIFO_DEPTH.
//  Beat accepted = sink valid & sink ready.
//  Write FSM:
//   IDLE    ready=1. Beat with sop -> write word, verdict <= |channel, go RECV (or DECIDE if eop
//           on the same beat). Beat without sop -> discarded, no count.
//   RECV    ready=1. Each beat written, verdict |= |channel. eop -> DECIDE. sop beat -> previous
//           packet truncated: wr_ptr <= cmt_ptr, drop_cnt++, the sop beat starts a new packet.
//           Beat while full -> wr_ptr <= cmt_ptr, go DISCARD (oversize).
//   DECIDE  one cycle, ready=0. Verdict |= |channel of this cycle (classifier flags a match on the
//           final beat one cycle after eop). Pass: cmt_ptr <= wr_ptr, pass_cnt++. Fail:
//           wr_ptr <= cmt_ptr, drop_cnt++. -> IDLE.
//   DISCARD ready=1, beats discarded until eop accepted, then drop_cnt++ -> IDLE. sop beat while
//           in DISCARD: drop_cnt++, start new packet as in IDLE.
//  Channel is sampled every cycle from sop acceptance through DECIDE, including idle cycles
//   between beats (verdict is sticky).
//  Read side: words between rd_ptr and cmt_ptr only; uncommitted data never reaches src.
//   Sync memory (1-cycle read) + one output register. Src holds data/sop/eop/empty stable while
//   valid & !ready. First beat of a passed packet appears on src exactly 2 cycles after DECIDE
//   when the output stage is empty; full throughput (1 beat/cycle) after that with ready high.
//  A packet that fits in the buffer space left by unread data is never dropped for size. Sink
//   stalls only in DECIDE; no back-pressure from src into a packet in progress beyond the free
//   space of the buffer.
//  Simultaneous events: DECIDE commit and a read in the same cycle are legal; full is evaluated
//   from the registered rd_ptr. Counters saturate and do not wrap.
// STRUCTURE
//  packet_resolver_pkg: wr_state_t enum {IDLE, RECV, DECIDE, DISCARD}, word struct
//   {data, sop, eop, empty} parameterised by DATA_WIDTH, helper for EMPTY_WIDTH.
//  Sub-module resolver_buf: simple dual-port RAM (FIFO_DEPTH x word), registered read. FSM,
//   pointers and output stage stay in packet_resolver.
// TESTING
//  1) 4-beat packet, channel=1 on beat 2 only, src ready=1 -> same 4 beats out, first out 2 cycles
//     after DECIDE; pass_cnt=1, drop_cnt=0.
//  2) 3-beat packet, channel=1 only in the cycle after eop -> forwarded (late verdict); 3-beat
//     packet with channel=0 throughout -> nothing on src, drop_cnt=1.
//  3) Fail packet A (5 beats) then pass packet B (2 beats) back-to-back -> only B on src, in
//     order, empty field preserved (empty=2 on eop).
//  4) FIFO_DEPTH=8, 10-beat packet with channel=1 -> dropped via DISCARD, drop_cnt=1, sink ready
//     never deasserted, a following 2-beat pass packet is forwarded intact.
//  5) sop at beat 3 of an open packet -> first packet dropped (drop_cnt=1), second forwarded if
//     matched; src ready toggled randomly -> data stable while stalled, no loss or duplication.
//  6) rst_n_i pulsed low mid-packet and mid-readout -> src valid=0 and counters=0 immediately;
//     next packet after reset processed normally.

Source files
------------

// File: rtl/packet_resolver_pkg.sv
// Shared types and width helpers for the packet resolver store-and-forward stage.
package packet_resolver_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RECV    = 2'd1,
      DECIDE  = 2'd2,
      DISCARD = 2'd3
   } wr_state_t;

   // Width of the Avalon-ST empty field for a symbol-packed bus of 8-bit symbols.
   function automatic int empty_width(input int data_width);
      return (data_width > 8) ? $clog2(data_width / 8) : 1;
   endfunction

endpackage

// File: rtl/resolver_buf.sv
// Simple dual-port packet buffer: one write port, one read port with a registered,
// enable-gated output that holds its word until the next read.
module resolver_buf
   import packet_resolver_pkg::*;
#(
   parameter  int WORD_W = 36,
   parameter  int DEPTH  = 256,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WORD_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WORD_W-1:0] rd_data
);

   logic [WORD_W-1:0] mem [DEPTH];

   always_ff @(posedge clk_i) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/packet_resolver.sv
// Store-and-forward resolver: buffers each packet, applies the sticky classifier
// verdict, forwards matched packets and drops the rest with saturating counters.
module packet_resolver
   import packet_resolver_pkg::*;
#(
   parameter  int DATA_WIDTH    = 32,
   parameter  int CHANNEL_WIDTH = 1,
   parameter  int FIFO_DEPTH    = 256,
   parameter  int CNT_WIDTH     = 16,
   localparam int EMPTY_W       = empty_width(DATA_WIDTH)
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic [DATA_WIDTH-1:0]    ast_sink_data,
   input  logic                     ast_sink_valid,
   output logic                     ast_sink_ready,
   input  logic                     ast_sink_sop,
   input  logic                     ast_sink_eop,
   input  logic [EMPTY_W-1:0]       ast_sink_empty,
   input  logic [CHANNEL_WIDTH-1:0] ast_sink_channel,
   output logic [DATA_WIDTH-1:0]    ast_src_data,
   output logic                     ast_src_valid,
   input  logic                     ast_src_ready,
   output logic                     ast_src_sop,
   output logic                     ast_src_eop,
   output logic [EMPTY_W-1:0]       ast_src_empty,
   output logic [CHANNEL_WIDTH-1:0] ast_src_channel,
   output logic [CNT_WIDTH-1:0]     pass_cnt_o,
   output logic [CNT_WIDTH-1:0]     drop_cnt_o,
   output logic [1:0]               wr_state_o
);

   // Avalon-ST handshake: a beat transfers on every cycle with valid & ready; src keeps
   // data/sop/eop/empty stable while valid & !ready; sink ready drops only in DECIDE.

   localparam int ADDR_W = $clog2(FIFO_DEPTH);
   localparam int PTR_W  = ADDR_W + 1;
   localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(FIFO_DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic                  sop;
      logic                  eop;
      logic [EMPTY_W-1:0]    empty;
   } word_t;

   wr_state_t         state_q, state_d, start_state;
   logic              run_q;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, cmt_ptr_q, cmt_ptr_d, rd_ptr_q;
   logic              verdict_q, verdict_d;
   logic              beat, ch_hit, full_w, full_c, start;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic              pass_inc;
   logic [1:0]        drop_inc;
   word_t             wr_word, rd_word, out_q;
   logic              mem_vld_q, out_vld_q, rd_en, out_load, avail;
   logic [CNT_WIDTH-1:0] pass_cnt_q, drop_cnt_q;
   logic [CNT_WIDTH:0]   pass_sum, drop_sum;

   assign ast_sink_ready = run_q && (state_q != DECIDE);
   assign beat    = ast_sink_valid & ast_sink_ready;
   assign ch_hit  = |ast_sink_channel;
   assign full_w  = (wr_ptr_q - rd_ptr_q) == DEPTH_P;
   assign full_c  = (cmt_ptr_q - rd_ptr_q) == DEPTH_P;
   assign wr_word = '{data: ast_sink_data, sop: ast_sink_sop, eop: ast_sink_eop,
                      empty: ast_sink_empty};

   // A new packet always starts at the commit point; with no room it is oversize at once.
   assign start_state = full_c ? (ast_sink_eop ? IDLE : DISCARD)
                               : (ast_sink_eop ? DECIDE : RECV);

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (beat && ast_sink_sop) state_d = start_state;
         RECV:    if (beat) begin
                     if (ast_sink_sop)      state_d = start_state;
                     else if (full_w)       state_d = ast_sink_eop ? IDLE : DISCARD;
                     else if (ast_sink_eop) state_d = DECIDE;
                  end
         DECIDE:  state_d = IDLE;
         DISCARD: if (beat) begin
                     if (ast_sink_sop)      state_d = start_state;
                     else if (ast_sink_eop) state_d = IDLE;
                  end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = cmt_ptr_q[ADDR_W-1:0];
      wr_ptr_d  = wr_ptr_q;
      cmt_ptr_d = cmt_ptr_q;
      verdict_d = verdict_q;
      pass_inc  = 1'b0;
      drop_inc  = 2'd0;
      start     = 1'b0;
      case (state_q)
         IDLE: start = beat & ast_sink_sop;
         RECV: begin
            if (beat && ast_sink_sop) begin
               start    = 1'b1;
               drop_inc = 2'd1;
            end else begin
               verdict_d = verdict_q | ch_hit;
               if (beat) begin
                  if (full_w) begin
                     wr_ptr_d = cmt_ptr_q;
                     if (ast_sink_eop) drop_inc = 2'd1;
                  end else begin
                     mem_we    = 1'b1;
                     mem_waddr = wr_ptr_q[ADDR_W-1:0];
                     wr_ptr_d  = wr_ptr_q + PTR_ONE;
                  end
               end
            end
         end
         DECIDE: begin
            if (verdict_q | ch_hit) begin
               cmt_ptr_d = wr_ptr_q;
               pass_inc  = 1'b1;
            end else begin
               wr_ptr_d = cmt_ptr_q;
               drop_inc = 2'd1;
            end
         end
         DISCARD: begin
            if (beat) begin
               if (ast_sink_sop) begin
                  start    = 1'b1;
                  drop_inc = 2'd1;
               end else if (ast_sink_eop) begin
                  drop_inc = 2'd1;
               end
            end
         end
         default: ;
      endcase
      if (start) begin
         if (!full_c) begin
            mem_we    = 1'b1;
            mem_waddr = cmt_ptr_q[ADDR_W-1:0];
            wr_ptr_d  = cmt_ptr_q + PTR_ONE;
            verdict_d = ch_hit;
         end else begin
            wr_ptr_d = cmt_ptr_q;
            if (ast_sink_eop) drop_inc = drop_inc + 2'd1;
         end
      end
   end

   // Reads look at the next commit point so a passed packet starts reading in DECIDE.
   assign avail    = (rd_ptr_q != cmt_ptr_d);
   assign out_load = mem_vld_q & (~out_vld_q | ast_src_ready);
   assign rd_en    = avail & (~mem_vld_q | out_load);

   assign pass_sum = {1'b0, pass_cnt_q} + (CNT_WIDTH+1)'(pass_inc);
   assign drop_sum = {1'b0, drop_cnt_q} + (CNT_WIDTH+1)'(drop_inc);

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         run_q      <= 1'b0;
         wr_ptr_q   <= '0;
         cmt_ptr_q  <= '0;
         rd_ptr_q   <= '0;
         verdict_q  <= 1'b0;
         mem_vld_q  <= 1'b0;
         out_vld_q  <= 1'b0;
         out_q      <= '0;
         pass_cnt_q <= '0;
         drop_cnt_q <= '0;
      end else begin
         run_q      <= 1'b1;
         wr_ptr_q   <= wr_ptr_d;
         cmt_ptr_q  <= cmt_ptr_d;
         verdict_q  <= verdict_d;
         if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_ONE;
         mem_vld_q  <= rd_en | (mem_vld_q & ~out_load);
         out_vld_q  <= out_load | (out_vld_q & ~ast_src_ready);
         if (out_load) out_q <= rd_word;
         pass_cnt_q <= pass_sum[CNT_WIDTH] ? '1 : pass_sum[CNT_WIDTH-1:0];
         drop_cnt_q <= drop_sum[CNT_WIDTH] ? '1 : drop_sum[CNT_WIDTH-1:0];
      end
   end

   resolver_buf #(
      .WORD_W ($bits(word_t)),
      .DEPTH  (FIFO_DEPTH)
   ) u_buf (
      .clk_i   (clk_i),
      .wr_en   (mem_we),
      .wr_addr (mem_waddr),
      .wr_data (wr_word),
      .rd_en   (rd_en),
      .rd_addr (rd_ptr_q[ADDR_W-1:0]),
      .rd_data (rd_word)
   );

   assign ast_src_data    = out_q.data;
   assign ast_src_sop     = out_q.sop;
   assign ast_src_eop     = out_q.eop;
   assign ast_src_empty   = out_q.empty;
   assign ast_src_valid   = out_vld_q;
   assign ast_src_channel = '0;
   assign pass_cnt_o      = pass_cnt_q;
   assign drop_cnt_o      = drop_cnt_q;
   assign wr_state_o      = state_q;

endmodule

// File: tb/tb_packet_resolver.sv
// Bench for packet_resolver with a small buffer and narrow counters so the oversize
// and saturation boundaries are reachable; expected src words live in a scoreboard queue.
module tb_packet_resolver;

   localparam int DW      = 32;
   localparam int CW      = 1;
   localparam int DEPTH   = 8;
   localparam int CNT_W   = 4;
   localparam int EW      = 2;
   localparam int WORD_W  = DW + 2 + EW;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic          clk_i = 1'b0;
   logic          rst_n_i = 1'b0;
   logic [DW-1:0] sink_data = '0;
   logic          sink_valid = 1'b0, sink_ready, sink_sop = 1'b0, sink_eop = 1'b0;
   logic [EW-1:0] sink_empty = '0;
   logic [CW-1:0] sink_channel = '0;
   logic [DW-1:0] src_data;
   logic          src_valid, src_ready, src_sop, src_eop;
   logic [EW-1:0] src_empty;
   logic [CW-1:0] src_channel;
   logic [CNT_W-1:0] pass_cnt, drop_cnt;
   logic [1:0]    wr_state;
   logic [WORD_W-1:0] src_word;

   int n_cmp = 0, n_err = 0;
   logic [WORD_W-1:0] exp_q[$];
   int exp_pass = 0, exp_drop = 0;
   int cycle_cnt = 0, eop_cyc = 0, last_sop_cyc = 0, stall_cnt = 0, rdy_mode = 0;
   logic hold_q = 1'b0;
   logic [WORD_W-1:0] hold_word = '0;

   packet_resolver #(
      .DATA_WIDTH(DW), .CHANNEL_WIDTH(CW), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CNT_W)
   ) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i),
      .ast_sink_data(sink_data), .ast_sink_valid(sink_valid), .ast_sink_ready(sink_ready),
      .ast_sink_sop(sink_sop), .ast_sink_eop(sink_eop), .ast_sink_empty(sink_empty),
      .ast_sink_channel(sink_channel),
      .ast_src_data(src_data), .ast_src_valid(src_valid), .ast_src_ready(src_ready),
      .ast_src_sop(src_sop), .ast_src_eop(src_eop), .ast_src_empty(src_empty),
      .ast_src_channel(src_channel),
      .pass_cnt_o(pass_cnt), .drop_cnt_o(drop_cnt), .wr_state_o(wr_state)
   );

   // clock / reset-independent infrastructure
   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cycle_cnt <= cycle_cnt + 1;
   assign src_word = {src_data, src_sop, src_eop, src_empty};

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic int sat_inc(input int v);
      return (v >= CNT_MAX) ? CNT_MAX : v + 1;
   endfunction

   initial begin
      src_ready = 1'b1;
      forever begin
         @(posedge clk_i);
         #1;
         case (rdy_mode)
            0:       src_ready = 1'b1;
            1:       src_ready = 1'($urandom_range(0, 1));
            default: src_ready = 1'b0;
         endcase
      end
   end

   // scoreboard / monitor on the falling edge
   always @(negedge clk_i) begin
      if (!rst_n_i) begin
         hold_q <= 1'b0;
      end else begin
         if (hold_q) begin
            check_eq("src_stall_valid", 64'(src_valid), 64'd1);
            check_eq("src_stall_word", 64'(src_word), 64'(hold_word));
         end
         if (src_valid && src_ready) begin
            if (exp_q.size() == 0) begin
               check_eq("src_unexpected_beat", 64'(exp_q.size()), 64'd1);
            end else begin
               check_eq("src_word", 64'(src_word), 64'(exp_q[0]));
               void'(exp_q.pop_front());
               if (src_sop) last_sop_cyc <= cycle_cnt;
            end
         end
         hold_q    <= src_valid && !src_ready;
         hold_word <= src_word;
      end
   end

   // driver tasks
   task automatic drive_beat(input logic [DW-1:0] d, input logic sop, input logic eop,
                             input logic [EW-1:0] emp, input logic ch);
      int w;
      sink_data = d; sink_sop = sop; sink_eop = eop; sink_empty = emp;
      sink_channel = CW'(ch); sink_valid = 1'b1;
      w = 0;
      @(negedge clk_i);
      while (!sink_ready && w < 50) begin
         w++;
         stall_cnt++;
         @(negedge clk_i);
      end
      if (w >= 50) check_eq("sink_ready_timeout", 64'(sink_ready), 64'd1);
      @(posedge clk_i);
      #1;
      sink_valid = 1'b0; sink_channel = '0;
   endtask

   // hit = beat index carrying channel=1, n = the cycle after eop, -1 = never
   task automatic send_pkt(input int n, input int hit, input logic [EW-1:0] last_emp);
      logic pass;
      logic [DW-1:0] d;
      logic [EW-1:0] emp;
      pass = (hit >= 0) && (hit <= n) && (n <= DEPTH);
      for (int i = 0; i < n; i++) begin
         d   = $urandom;
         emp = (i == n - 1) ? last_emp : '0;
         if (pass) exp_q.push_back({d, i == 0, i == n - 1, emp});
         drive_beat(d, i == 0, i == n - 1, emp, i == hit);
      end
      eop_cyc = cycle_cnt;
      if (n <= DEPTH) begin
         sink_channel = CW'(hit == n);
         @(negedge clk_i);
         check_eq("decide_sink_ready", 64'(sink_ready), 64'd0);
         @(posedge clk_i);
         #1;
         sink_channel = '0;
      end
      if (pass) exp_pass = sat_inc(exp_pass);
      else      exp_drop = sat_inc(exp_drop);
   endtask

   task automatic wait_drain(input string tag);
      int k;
      k = 0;
      while ((exp_q.size() != 0 || src_valid) && k < 400) begin
         @(negedge clk_i);
         k++;
      end
      if (k >= 400) check_eq(tag, 64'(exp_q.size()), 64'd0);
      repeat (2) @(posedge clk_i);
      #1;
   endtask

   task automatic check_counts(input string tag);
      check_eq({tag, "_pass_cnt"}, 64'(pass_cnt), 64'(exp_pass));
      check_eq({tag, "_drop_cnt"}, 64'(drop_cnt), 64'(exp_drop));
   endtask

   task automatic reset_mid_flight(input string tag);
      rst_n_i = 1'b0;
      sink_valid = 1'b0;
      #1;
      check_eq({tag, "_src_valid"}, 64'(src_valid), 64'd0);
      check_eq({tag, "_pass_cnt"}, 64'(pass_cnt), 64'd0);
      check_eq({tag, "_drop_cnt"}, 64'(drop_cnt), 64'd0);
      check_eq({tag, "_sink_ready"}, 64'(sink_ready), 64'd0);
      exp_q.delete();
      exp_pass = 0;
      exp_drop = 0;
      repeat (2) @(posedge clk_i);
      #1;
      rst_n_i = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not complete in time");
      $fatal(1);
   end

   initial begin
      int n, hit, w;
      repeat (3) @(posedge clk_i);
      #1;
      check_eq("rst_src_valid", 64'(src_valid), 64'd0);
      check_eq("rst_src_sop_eop", 64'({src_sop, src_eop}), 64'd0);
      check_eq("rst_src_data", 64'(src_data), 64'd0);
      check_eq("rst_src_empty", 64'(src_empty), 64'd0);
      check_eq("rst_src_channel", 64'(src_channel), 64'd0);
      check_eq("rst_sink_ready", 64'(sink_ready), 64'd0);
      check_counts("rst");
      rst_n_i = 1'b1;

      // single 4-beat pass packet and its output latency
      send_pkt(4, 1, 2'd0);
      wait_drain("t1_drain");
      check_eq("t1_latency", 64'(last_sop_cyc - eop_cyc), 64'd2);
      check_counts("t1");

      // stray beat without sop is ignored; late verdict; silent drop
      drive_beat(32'hDEAD_BEEF, 1'b0, 1'b1, 2'd0, 1'b1);
      send_pkt(3, 3, 2'd1);
      send_pkt(3, -1, 2'd0);
      wait_drain("t2_drain");
      check_counts("t2");

      // fail then pass back to back, empty preserved
      send_pkt(5, -1, 2'd0);
      send_pkt(2, 0, 2'd2);
      wait_drain("t3_drain");
      check_counts("t3");

      // oversize packet, then a follow-up and an exactly-full packet
      stall_cnt = 0;
      send_pkt(10, 0, 2'd0);
      check_eq("t4_sink_never_stalled", 64'(stall_cnt), 64'd0);
      send_pkt(2, 1, 2'd1);
      wait_drain("t4_drain_a");
      send_pkt(DEPTH, DEPTH - 1, 2'd3);
      wait_drain("t4_drain_b");
      check_counts("t4");

      // sop at beat 3 truncates the open packet
      drive_beat($urandom, 1'b1, 1'b0, 2'd0, 1'b0);
      drive_beat($urandom, 1'b0, 1'b0, 2'd0, 1'b0);
      exp_drop = sat_inc(exp_drop);
      send_pkt(4, 2, 2'd1);
      wait_drain("t5_drain");
      check_counts("t5_trunc");

      // random src back-pressure over random packets
      rdy_mode = 1;
      for (int i = 0; i < 20; i++) begin
         n   = $urandom_range(1, DEPTH);
         hit = $urandom_range(0, n + 1);
         if (hit == n + 1) hit = -1;
         send_pkt(n, hit, 2'($urandom_range(0, 3)));
         wait_drain("t5_rand_drain");
      end
      rdy_mode = 0;
      wait_drain("t5_rand_end");
      check_counts("t5_rand");

      // counter saturation
      for (int i = 0; i < CNT_MAX + 1; i++) begin
         send_pkt(1, 0, 2'd3);
         send_pkt(1, -1, 2'd0);
      end
      wait_drain("sat_drain");
      check_eq("sat_pass_cnt", 64'(pass_cnt), 64'(CNT_MAX));
      check_eq("sat_drop_cnt", 64'(drop_cnt), 64'(CNT_MAX));
      check_counts("sat");

      // reset mid-packet
      drive_beat($urandom, 1'b1, 1'b0, 2'd0, 1'b1);
      drive_beat($urandom, 1'b0, 1'b0, 2'd0, 1'b0);
      drive_beat($urandom, 1'b0, 1'b0, 2'd0, 1'b0);
      reset_mid_flight("t6_rst_pkt");

      // reset mid-readout
      rdy_mode = 2;
      send_pkt(6, 0, 2'd0);
      w = 0;
      while (!src_valid && w < 20) begin
         @(negedge clk_i);
         w++;
      end
      if (w >= 20) check_eq("t6_readout_start", 64'(src_valid), 64'd1);
      repeat (3) @(posedge clk_i);
      rdy_mode = 0;
      repeat (3) @(posedge clk_i);
      #2;
      reset_mid_flight("t6_rst_read");

      send_pkt(3, 1, 2'd1);
      wait_drain("t6_drain");
      check_counts("t6_after");
      check_eq("final_queue_empty", 64'(exp_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
